// File: rtl/four_bank_mem_resp.sv
// Four-bank interleaved word memory responder: per-bank busy counters, stall back-pressure,
// fixed 2-cycle read latency. Optional macro FBM_ALIGN_CHECK_EN flags odd byte addresses as illegal.
module four_bank_mem_resp #(
    parameter int DEPTH_LOG2  = 13,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int                CW       = (BANK_CYCLES > 2) ? $clog2(BANK_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'(BANK_CYCLES - 1);
    localparam int                WORDS    = 4 << DEPTH_LOG2;

    logic [1:0]             bank;
    logic [DEPTH_LOG2-1:0]  row;
    logic [DEPTH_LOG2+1:0]  mem_idx;
    logic                   req;
    logic                   illegal;
    logic                   accept;
    logic                   rd_acc;
    logic                   wr_acc;

    assign bank    = addr[2:1];
    assign row     = addr[DEPTH_LOG2+2:3];
    assign mem_idx = {row, bank};
    assign req     = rd | wr;

`ifdef FBM_ALIGN_CHECK_EN
    assign illegal = (rd & wr) | (req & addr[0]);
`else
    logic unused_addr_lane;
    assign unused_addr_lane = addr[0];
    assign illegal = rd & wr;
`endif

    // Priority: illegal beats stall beats accept.
    assign err    = illegal;
    assign stall  = req & ~illegal & busy[bank];
    assign accept = req & ~illegal & ~busy[bank];
    assign rd_acc = accept & rd;
    assign wr_acc = accept & wr;

    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (accept && (bank == 2'(gi))) begin
                    cnt_d[gi] = CNT_LOAD;
                end else if (cnt_q[gi] != '0) begin
                    cnt_d[gi] = cnt_q[gi] - CW'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end

            assign busy[gi] = (cnt_q[gi] != '0);
        end
    endgenerate

    // Banks share one array indexed {row, bank}; at most one access per cycle, so no port conflict.
    logic [15:0] mem [WORDS];
    logic [15:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[mem_idx] <= data_in;
        end
        if (rd_acc) begin
            rd_data_q <= mem[mem_idx];
        end
    end

    logic        s1_valid_q;
    logic        s2_valid_q;
    logic [15:0] s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= rd_data_q;
        end
    end

    assign data_out = s2_valid_q ? s2_data_q : 16'h0000;

endmodule
